// File: rtl/scan_param.sv
// Console input scanner: returns one raw character or a hex number of up to MAX_DIGITS digits.
// Optional backspace editing in hex mode is enabled by defining BACKSPACE_EN.
module scan_param #(
   parameter int unsigned MAX_DIGITS = 8,
   parameter int unsigned DATA_W     = 4 * MAX_DIGITS,
   parameter bit          AUTO_END   = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        d_rx,
   input  logic              vld_rx,
   output logic              rdy_rx,
   input  logic              req_rx,
   input  logic              type_rx,
   output logic              ack_rx,
   output logic [DATA_W-1:0] din_rx,
   output logic [4:0]        cnt_rx,
   output logic              flag_rx,
   output logic              err_rx
);

   localparam int unsigned CNT_W   = 5;
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      DONE
   } state_t;

   state_t              state_q, state_d;
   logic                rdy_q, rdy_d;
   logic                ack_q, ack_d;
   logic                type_q, type_d;
   logic [DATA_W-1:0]   din_q, din_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                flag_q, flag_d;
   logic                err_q, err_d;
   logic                finish;
   logic [4:0]          hex_v;

   // {valid, nibble} for an ASCII hex digit
   function automatic logic [4:0] hex_decode(input logic [7:0] b);
      logic [4:0] r;
      r = 5'd0;
      if (b >= 8'h30 && b <= 8'h39)      r = {1'b1, 4'(b - 8'h30)};
      else if (b >= 8'h41 && b <= 8'h46) r = {1'b1, 4'(b - 8'h37)};
      else if (b >= 8'h61 && b <= 8'h66) r = {1'b1, 4'(b - 8'h57)};
      return r;
   endfunction

   always_comb begin
      state_d = state_q;
      rdy_d   = rdy_q;
      ack_d   = ack_q;
      type_d  = type_q;
      din_d   = din_q;
      cnt_d   = cnt_q;
      flag_d  = flag_q;
      err_d   = err_q;
      finish  = 1'b0;
      hex_v   = hex_decode(d_rx);

      case (state_q)
         IDLE: begin
            rdy_d = 1'b0;
            ack_d = 1'b0;
            if (req_rx && !ack_q) begin
               din_d   = '0;
               cnt_d   = '0;
               flag_d  = 1'b0;
               err_d   = 1'b0;
               type_d  = type_rx;
               rdy_d   = 1'b1;
               state_d = COLLECT;
            end
         end
         COLLECT: begin
            // abort outranks any byte arriving in the same cycle
            if (!req_rx) begin
               rdy_d   = 1'b0;
               state_d = IDLE;
            end else if (vld_rx) begin
               if (!type_q) begin
                  din_d  = DATA_W'(d_rx);
                  flag_d = (d_rx == 8'h0D);
                  finish = 1'b1;
               end else if (hex_v[4]) begin
                  if (cnt_q < MAX_CNT) begin
                     din_d = DATA_W'(din_q << 4) | DATA_W'(hex_v[3:0]);
                     cnt_d = cnt_q + 5'd1;
                     if (AUTO_END && (cnt_d == MAX_CNT)) finish = 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
               end else if (d_rx == 8'h20) begin
                  if (cnt_q != 5'd0) finish = 1'b1;
               end else if (d_rx == 8'h0D) begin
                  flag_d = (cnt_q == 5'd0);
                  finish = 1'b1;
`ifdef BACKSPACE_EN
               end else if (d_rx == 8'h08 || d_rx == 8'h7F) begin
                  if (cnt_q != 5'd0) begin
                     din_d = din_q >> 4;
                     cnt_d = cnt_q - 5'd1;
                  end
`endif
               end else begin
                  err_d = 1'b1;
               end
               if (finish) begin
                  rdy_d   = 1'b0;
                  ack_d   = 1'b1;
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            ack_d = 1'b1;
            if (!req_rx) begin
               ack_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            rdy_d   = 1'b0;
            ack_d   = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rdy_q   <= 1'b0;
         ack_q   <= 1'b0;
         type_q  <= 1'b0;
         din_q   <= '0;
         cnt_q   <= '0;
         flag_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rdy_q   <= rdy_d;
         ack_q   <= ack_d;
         type_q  <= type_d;
         din_q   <= din_d;
         cnt_q   <= cnt_d;
         flag_q  <= flag_d;
         err_q   <= err_d;
      end
   end

   assign rdy_rx  = rdy_q;
   assign ack_rx  = ack_q;
   assign din_rx  = din_q;
   assign cnt_rx  = cnt_q;
   assign flag_rx = flag_q;
   assign err_rx  = err_q;

endmodule

// File: tb/tb_scan_param.sv
// Directed scoreboard bench for scan_param: one AUTO_END=1 and one AUTO_END=0 instance, selected by sel.
module tb_scan_param;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  d_rx;
   logic        vld, req, type_rx, sel;

   logic        req_a, req_b, vld_a, vld_b;
   logic        rdy_a, ack_a, flag_a, err_a;
   logic        rdy_b, ack_b, flag_b, err_b;
   logic [31:0] din_a, din_b;
   logic [4:0]  cnt_a, cnt_b;

   logic        rdy_m, ack_m, flag_m, err_m;
   logic [31:0] din_m;
   logic [4:0]  cnt_m;

   always #5 clk = ~clk;

   assign req_a = req & ~sel;
   assign req_b = req & sel;
   assign vld_a = vld & ~sel;
   assign vld_b = vld & sel;
   assign rdy_m  = sel ? rdy_b  : rdy_a;
   assign ack_m  = sel ? ack_b  : ack_a;
   assign din_m  = sel ? din_b  : din_a;
   assign cnt_m  = sel ? cnt_b  : cnt_a;
   assign flag_m = sel ? flag_b : flag_a;
   assign err_m  = sel ? err_b  : err_a;

   scan_param #(.MAX_DIGITS(8), .AUTO_END(1'b1)) u_dut_auto (
      .clk(clk), .rst(rst), .d_rx(d_rx), .vld_rx(vld_a), .rdy_rx(rdy_a),
      .req_rx(req_a), .type_rx(type_rx), .ack_rx(ack_a), .din_rx(din_a),
      .cnt_rx(cnt_a), .flag_rx(flag_a), .err_rx(err_a)
   );

   scan_param #(.MAX_DIGITS(8), .AUTO_END(1'b0)) u_dut_term (
      .clk(clk), .rst(rst), .d_rx(d_rx), .vld_rx(vld_b), .rdy_rx(rdy_b),
      .req_rx(req_b), .type_rx(type_rx), .ack_rx(ack_b), .din_rx(din_b),
      .cnt_rx(cnt_b), .flag_rx(flag_b), .err_rx(err_b)
   );

   typedef struct {
      logic [31:0] din;
      logic [4:0]  cnt;
      logic        flag;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_res(input logic [31:0] din, input logic [4:0] cnt,
                             input logic flag, input logic err);
      exp_t e;
      e.din = din; e.cnt = cnt; e.flag = flag; e.err = err;
      sb.push_back(e);
   endtask

   // Full four-phase transaction; returns how many bytes the scanner consumed
   task automatic run(input string tag, input logic t, input string s, output int used);
      exp_t e;
      int   n;
      type_rx = t;
      req     = 1'b1;
      @(posedge clk); #1;
      used = 0;
      while (used < s.len() && !ack_m && rdy_m) begin
         d_rx = s[used];
         vld  = 1'b1;
         @(posedge clk); #1;
         used++;
      end
      vld = 1'b0;
      n = 0;
      while (!ack_m && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, ".ack"}, 64'(ack_m), 64'd1);
      if (sb.size() == 0) begin
         check({tag, ".sb_empty"}, 64'd1, 64'd0);
      end else begin
         e = sb.pop_front();
         check({tag, ".din"},  64'(din_m),  64'(e.din));
         check({tag, ".cnt"},  64'(cnt_m),  64'(e.cnt));
         check({tag, ".flag"}, 64'(flag_m), 64'(e.flag));
         check({tag, ".err"},  64'(err_m),  64'(e.err));
      end
      check({tag, ".rdy_done"}, 64'(rdy_m), 64'd0);
      req = 1'b0;
      @(posedge clk); #1;
      check({tag, ".ack_drop"}, 64'(ack_m), 64'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      int used;
      rst = 1'b1; req = 1'b0; vld = 1'b0; d_rx = 8'h00; type_rx = 1'b0; sel = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst.rdy",  64'(rdy_m),  64'd0);
      check("rst.ack",  64'(ack_m),  64'd0);
      check("rst.din",  64'(din_m),  64'd0);
      check("rst.cnt",  64'(cnt_m),  64'd0);
      check("rst.flag", 64'(flag_m), 64'd0);
      check("rst.err",  64'(err_m),  64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      expect_res(32'h0000_1A2B, 5'd4, 1'b0, 1'b0);
      run("hex1A2b", 1'b1, "1A2b\015", used);

      expect_res(32'h0, 5'd0, 1'b1, 1'b0);
      run("hex_blank", 1'b1, "  \015", used);

      expect_res(32'h0000_000D, 5'd0, 1'b1, 1'b0);
      run("char_cr", 1'b0, "\015", used);

      expect_res(32'h1234_5678, 5'd8, 1'b0, 1'b0);
      run("auto_end", 1'b1, "123456789", used);
      check("auto_end.used", 64'(used), 64'd8);

      expect_res(32'h0000_0012, 5'd2, 1'b0, 1'b1);
      run("bad_char", 1'b1, "1G2\015", used);

`ifdef BACKSPACE_EN
      expect_res(32'h0000_00AC, 5'd2, 1'b0, 1'b0);
`else
      expect_res(32'h0000_0ABC, 5'd3, 1'b0, 1'b1);
`endif
      run("bksp", 1'b1, "AB\010C\015", used);

      sel = 1'b1;
      @(posedge clk); #1;
      expect_res(32'h1234_5678, 5'd8, 1'b0, 1'b1);
      run("term_over", 1'b1, "123456789 ", used);
      check("term_over.used", 64'(used), 64'd10);
      sel = 1'b0;
      @(posedge clk); #1;

      // abort after two digits, then a fresh char request
      type_rx = 1'b1; req = 1'b1;
      @(posedge clk); #1;
      d_rx = "1"; vld = 1'b1;
      @(posedge clk); #1;
      d_rx = "2";
      @(posedge clk); #1;
      vld = 1'b0; req = 1'b0;
      @(posedge clk); #1;
      check("abort.rdy", 64'(rdy_m), 64'd0);
      check("abort.ack", 64'(ack_m), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      check("abort.ack_late", 64'(ack_m), 64'd0);
      expect_res(32'h0000_0078, 5'd0, 1'b0, 1'b0);
      run("after_abort", 1'b0, "x", used);

      // reset in the middle of a hex collection
      type_rx = 1'b1; req = 1'b1;
      @(posedge clk); #1;
      d_rx = "A"; vld = 1'b1;
      @(posedge clk); #1;
      d_rx = "G";
      @(posedge clk); #1;
      vld = 1'b0;
      check("pre_rst.err", 64'(err_m), 64'd1);
      check("pre_rst.din", 64'(din_m), 64'hA);
      rst = 1'b1;
      @(posedge clk); #1;
      check("mid_rst.rdy",  64'(rdy_m),  64'd0);
      check("mid_rst.ack",  64'(ack_m),  64'd0);
      check("mid_rst.din",  64'(din_m),  64'd0);
      check("mid_rst.cnt",  64'(cnt_m),  64'd0);
      check("mid_rst.flag", 64'(flag_m), 64'd0);
      check("mid_rst.err",  64'(err_m),  64'd0);
      rst = 1'b0; req = 1'b0;
      @(posedge clk); #1;

      check("sb.drained", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/scan_param.md
Name: scan_param

Overview:
Parametrised console input scanner for the serial debug unit. It sits between the UART receiver byte stream and the command FSM. On a command-FSM request it consumes ASCII bytes and returns one of two results: a single raw character, or a hex number of up to MAX_DIGITS digits. Compared with the previous scanner it adds configurable digit count, an optional auto-terminate, a digit count output, an error flag, request abort, and optional backspace editing.

Parameters:
MAX_DIGITS, 8, maximum hex digits per number (1..16).
DATA_W, 4*MAX_DIGITS, width of din_rx; fixed as derived, not overridden independently.
AUTO_END, 1, 1 = number completes automatically on the MAX_DIGITS-th digit; 0 = a terminator is required.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
d_rx  in  8  received byte from UART RX
vld_rx  in  1  d_rx valid
rdy_rx  out  1  scanner ready; a byte transfers on a cycle with vld_rx && rdy_rx
req_rx  in  1  request from command FSM, held high until ack_rx seen
type_rx  in  1  0 = single character, 1 = hex number; sampled at request start
ack_rx  out  1  result valid; held until req_rx falls
din_rx  out  DATA_W  result: zero-extended char or hex value
cnt_rx  out  5  number of hex digits in result (0 in char mode)
flag_rx  out  1  empty result (bare CR)
err_rx  out  1  at least one byte was rejected during this transaction

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high (rst). All state updates happen on the rising clk edge.
- Reset: state IDLE. rdy_rx, ack_rx, flag_rx and err_rx are 0. din_rx and cnt_rx are 0. Reset mid-transaction drops the transaction; no ack is produced.
- States: IDLE, COLLECT, DONE.
- IDLE:
  - rdy_rx=0, ack_rx=0.
  - When req_rx=1 and ack_rx=0: clear din_rx, cnt_rx, flag_rx and err_rx; latch type_rx; go to COLLECT and set rdy_rx=1 at the same edge.
- COLLECT: rdy_rx=1. An accepted byte is decoded as follows.
  - Char mode: the first accepted byte completes the transaction. din_rx={0,d_rx}. flag_rx=1 if the byte is 0x0D.
  - Hex mode, 0-9/A-F/a-f with cnt_rx<MAX_DIGITS: din_rx={din_rx[DATA_W-5:0],nibble}, cnt_rx+1. Leading zeros count as digits. If AUTO_END=1 and the new cnt_rx equals MAX_DIGITS, the transaction completes.
  - Hex mode, hex digit with cnt_rx=MAX_DIGITS (only possible when AUTO_END=0): byte ignored, err_rx=1.
  - Hex mode, 0x20 with cnt_rx=0: skipped (leading space). 0x20 with cnt_rx>0: completes the transaction.
  - Hex mode, 0x0D: completes the transaction. flag_rx=1 if cnt_rx=0 (din_rx stays 0).
  - Hex mode, any other byte: ignored, err_rx=1.
- Completion: at the accepting edge, rdy_rx<=0, ack_rx<=1, state DONE. din_rx, cnt_rx, flag_rx and err_rx are stable from then until the next request start.
- DONE: ack_rx held at 1. When req_rx=0: ack_rx<=0 and state goes to IDLE (four-phase handshake). Outputs keep their values in IDLE until the next request.
- Abort: req_rx=0 while in COLLECT sets rdy_rx<=0 and the state goes to IDLE with no ack. If abort and a completing byte occur in the same cycle, abort wins and the byte is consumed.
- rdy_rx is never high outside COLLECT. vld_rx is ignored when rdy_rx=0.
- Throughput: one byte per cycle while in COLLECT.

Optional Feature:
BACKSPACE_EN.
- Defined: in hex mode, 0x08 or 0x7F with cnt_rx>0 sets din_rx<=din_rx>>4 and decrements cnt_rx; no error. With cnt_rx=0 the byte is ignored and no error is raised. In char mode both bytes are returned as ordinary characters.
- Undefined: 0x08 and 0x7F are invalid in hex mode (ignored, err_rx=1).

Test Plan:
- Hex "1A2b\r" (type=1, MAX_DIGITS=8) -> ack_rx=1, din_rx=0x00001A2B, cnt_rx=4, flag_rx=0, err_rx=0. ack_rx drops one cycle after req_rx falls.
- Hex "  \r" -> flag_rx=1, din_rx=0, cnt_rx=0. Char "\r" -> flag_rx=1, din_rx=0x0D.
- AUTO_END=1, bytes "123456789" -> ack_rx after the 8th digit, din_rx=0x12345678. The byte '9' is not consumed (rdy_rx=0).
- AUTO_END=0, "123456789 " -> din_rx=0x12345678, err_rx=1. Separately, "1G2\r" -> din_rx=0x12, err_rx=1.
- BACKSPACE_EN defined, "AB\x08C\r" -> din_rx=0xAC, cnt_rx=2, err_rx=0. Undefined -> din_rx=0xABC, err_rx=1.
- req_rx dropped after "12", then new char request "x" -> no ack for the first request; second ack_rx has din_rx=0x78, flag_rx=0. Asserting rst mid-COLLECT returns all outputs to 0 on the next edge.
